// File: rtl/ecc_168_pkg.sv
// Shared constants and the Hamming position-mask table for the 168-bit
// SECDED encoder. Data bit i sits at the i-th non-power-of-2 codeword
// position (1-based), so data bit 0 lands on position 3.
package ecc_168_pkg;

    localparam int DATA_WIDTH   = 168;
    localparam int PARITY_WIDTH = 9;
    localparam int HAM_WIDTH    = PARITY_WIDTH - 1;
    localparam int CODE_WIDTH   = DATA_WIDTH + HAM_WIDTH;

    // One mask per Hamming check bit, each selecting the data bits it covers
    typedef logic [HAM_WIDTH-1:0][DATA_WIDTH-1:0] ham_mask_t;

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Walk codeword positions, skipping check-bit slots (powers of 2), and
    // record which check bits cover each data bit. Powers of two above 2
    // are never adjacent, so a single skip per step is enough.
    function automatic ham_mask_t gen_ham_masks();
        ham_mask_t m;
        int        pos;
        m   = '0;
        pos = 2;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pos = pos + 1;
            if (is_pow2(pos)) begin
                pos = pos + 1;
            end
            for (int k = 0; k < HAM_WIDTH; k++) begin
                m[k][i] = ((pos >> k) & 1) != 0;
            end
        end
        return m;
    endfunction

    localparam ham_mask_t HAM_MASKS = gen_ham_masks();

endpackage

// File: rtl/ecc_168_enc.sv
// Combinational SECDED parity generator for one 168-bit word: eight
// Hamming check bits followed by one even overall-parity bit.
module ecc_168_enc
    import ecc_168_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [PARITY_WIDTH-1:0] parity_out
);

    logic [HAM_WIDTH-1:0] ham;

    // Each check bit is the XOR of its covered data bits; the top bit makes
    // the whole codeword (data plus check bits) even parity.
    always_comb begin
        ham = '0;
        for (int k = 0; k < HAM_WIDTH; k++) begin
            ham[k] = ^(data_in & HAM_MASKS[k]);
        end
        parity_out = {(^data_in) ^ (^ham), ham};
    end

endmodule

// File: rtl/ecc_168_enc_pipe.sv
// Write-side SECDED encoder with a redundant second encoder copy for fault
// detection. One handshake register stage carries data, copy-0 parity and
// the per-beat fault flag toward the storage write port; a sticky flag and
// a saturating counter summarise faults for the safety monitor.
module ecc_168_enc_pipe #(
    parameter int DATA_WIDTH   = ecc_168_pkg::DATA_WIDTH,
    parameter int PARITY_WIDTH = ecc_168_pkg::PARITY_WIDTH,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ecc_fault_detc_en,
    input  logic                    bypass,
    input  logic                    inj_en,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [PARITY_WIDTH-1:0] parity_out,
    output logic                    ecc_fault,
    output logic                    fault_sticky,
    output logic [CNT_WIDTH-1:0]    fault_cnt,
    input  logic                    fault_clr
);

    import ecc_168_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Counter step that sticks at all-ones instead of wrapping
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic                    accept_p0;
    logic [PARITY_WIDTH-1:0] par0_p0;
    logic [PARITY_WIDTH-1:0] par1_p0;
    logic [PARITY_WIDTH-1:0] par1_inj_p0;
    logic                    mismatch_p0;
    logic                    fault_p0;
    logic [PARITY_WIDTH-1:0] parity_sel_p0;

    logic                    vld_p1;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic [PARITY_WIDTH-1:0] parity_p1;
    logic                    fault_p1;
    logic                    sticky_q;
    logic [CNT_WIDTH-1:0]    cnt_q;

    // ---- stage p0: input handshake, redundant encode and compare ----
    assign in_rdy    = ~vld_p1 | out_rdy;
    assign accept_p0 = in_vld & in_rdy;

    ecc_168_enc u0_ecc_168_enc (
        .data_in    (data_in),
        .parity_out (par0_p0)
    );

    ecc_168_enc u1_ecc_168_enc (
        .data_in    (data_in),
        .parity_out (par1_p0)
    );

    // Injection flips check bit 0 of the shadow copy only, so the emitted
    // parity (always copy 0) stays golden while the compare must trip.
    assign par1_inj_p0   = par1_p0 ^ PARITY_WIDTH'(inj_en);
    assign mismatch_p0   = |(par0_p0 ^ par1_inj_p0);
    assign fault_p0      = mismatch_p0 & ecc_fault_detc_en & ~bypass;
    assign parity_sel_p0 = bypass ? '0 : par0_p0;

    // ---- stage p1: output register toward the write port ----
    // Load on accept, drop valid once the beat is taken, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            data_p1   <= '0;
            parity_p1 <= '0;
            fault_p1  <= 1'b0;
        end else if (accept_p0) begin
            vld_p1    <= 1'b1;
            data_p1   <= data_in;
            parity_p1 <= parity_sel_p0;
            fault_p1  <= fault_p0;
        end else if (out_rdy) begin
            vld_p1    <= 1'b0;
        end
    end

    // Fault bookkeeping: a faulty accepted beat outranks a same-cycle clear,
    // restarting the count at one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept_p0 && fault_p0) begin
            sticky_q <= 1'b1;
            cnt_q    <= fault_clr ? CNT_WIDTH'(1) : sat_inc(cnt_q);
        end else if (fault_clr) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end
    end

    assign out_vld      = vld_p1;
    assign data_out     = data_p1;
    assign parity_out   = parity_p1;
    assign ecc_fault    = fault_p1;
    assign fault_sticky = sticky_q;
    assign fault_cnt    = cnt_q;

endmodule

// File: doc/ecc_168_enc_pipe.md
Name: ecc_168_enc_pipe

Overview:
- Write-side partner of the ECC decode/fault-detect path: a SECDED parity generator for 168-bit words.
- Accepts data over a valid/ready handshake and computes parity in two redundant encoder copies.
- Compares the two copies and registers data, parity and fault status in a single pipeline stage toward the FIFO/RAM write port.
- Keeps a sticky fault flag and a saturating fault counter for the safety monitor.

Parameters:
- DATA_WIDTH, 168, data word width
- PARITY_WIDTH, 9, check bits: 8 Hamming plus 1 overall parity
- CNT_WIDTH, 8, fault counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ecc_fault_detc_en  in  1  enables the redundant-copy compare
- bypass  in  1  forces parity to 0 and suppresses fault
- inj_en  in  1  DFT hook: inverts parity bit 0 of copy 1 before the compare
- in_vld  in  1  input beat valid
- in_rdy  out  1  input beat accepted when in_vld & in_rdy
- data_in  in  DATA_WIDTH  write data
- out_vld  out  1  output beat valid
- out_rdy  in  1  downstream ready
- data_out  out  DATA_WIDTH  registered data
- parity_out  out  PARITY_WIDTH  registered parity from copy 0
- ecc_fault  out  1  per-beat fault, aligned with out_vld
- fault_sticky  out  1  set on any accepted faulty beat
- fault_cnt  out  CNT_WIDTH  count of faulty beats, saturating
- fault_clr  in  1  clears fault_sticky and fault_cnt

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values: out_vld=0, data_out=0, parity_out=0, ecc_fault=0, fault_sticky=0, fault_cnt=0.
- in_rdy = ~out_vld | out_rdy. This is combinational, gives full throughput and has no bubble.
- Pipeline register:
  - On accept (in_vld & in_rdy): load data_out, parity_out and ecc_fault; set out_vld=1.
  - Else if out_rdy: clear out_vld.
  - Else: hold all outputs stable while out_vld=1 & ~out_rdy.
  - Latency: 1 cycle from accept to out_vld.
- Encoding (identical in both copies):
  - Codeword positions run 1..176. Data bit i occupies the i-th non-power-of-2 position, so bit0 is at position 3.
  - parity[k], k=0..7, is the XOR of the data bits whose position has bit k set.
  - parity[8] is the XOR of all data bits and parity[7:0] (even overall parity).
  - This parity is bit-exact to the ecc_168_cal parity_out for the same data.
- Compare: mismatch = |(par0 ^ par1'), where par1' = par1 ^ {8'b0, inj_en}.
- Fault and parity per beat:
  - ecc_fault = mismatch & ecc_fault_detc_en & ~bypass.
  - parity_out is always taken from copy 0. On a fault, data still passes unchanged and only the flag marks the beat.
  - bypass=1: parity_out=0 and ecc_fault=0, regardless of inj_en.
- Fault bookkeeping:
  - Updated only on accepted beats with a fault.
  - fault_sticky is set to 1; fault_cnt increments and saturates at 2^CNT_WIDTH-1 without wrapping.
  - fault_clr alone: both are cleared next cycle.
  - fault_clr together with an accepted faulty beat: the new fault wins, giving fault_sticky=1 and fault_cnt=1.
- Reset asserted mid-transfer: the pending output beat is dropped and out_vld=0 next cycle; no partial state is retained.
- Control inputs (bypass, ecc_fault_detc_en, inj_en) are sampled only at accept. A change while output is stalled does not alter the held beat.

Decomposition:
- Package ecc_168_pkg:
  - DATA_WIDTH/PARITY_WIDTH constants.
  - Position-to-check-bit mask table: 8 masks of 168 bits, generated by a constant function.
- Sub-module ecc_168_enc: combinational data→parity encoder, instantiated twice (u0_ecc_168_enc, u1_ecc_168_enc).
- Top level: handshake register, compare and counters. Implementation size is about 150–250 lines total.

Test Plan:
- Basic encode: data_in=0 → parity_out=0x000. data_in=1 → parity_out=0x103. ecc_fault=0 in both cases; out_vld one cycle after accept.
- Backpressure: out_rdy=0 for 5 cycles while in_vld=1 with beats A,B → in_rdy=0 after A is accepted and A is held stable. Releasing out_rdy delivers A then B with no loss or duplication; back-to-back beats achieve 1 beat/cycle.
- Fault injection: inj_en=1, ecc_fault_detc_en=1, three beats → each ecc_fault=1, fault_sticky=1, fault_cnt=3, and parity_out still equals the golden parity.
- Masking: inj_en=1 with ecc_fault_detc_en=0 → ecc_fault=0 and fault_cnt unchanged. inj_en=1 with bypass=1 → parity_out=0x000 and ecc_fault=0.
- Counter boundaries: drive 260 faulty beats → fault_cnt=255 (saturated). fault_clr in the same cycle as a faulty accept → fault_cnt=1 and fault_sticky=1. fault_clr alone → 0/0.
- Reset mid-stall: out_vld=1 & out_rdy=0, then rst_n=0 for 1 cycle → out_vld=0, fault_cnt=0, in_rdy=1 next cycle.
- Round trip: random data through this block into ecc_168_cal with one data bit flipped → sbit_err=1 and the data is corrected.
